// File: rtl/regfile_wb_sched_pkg.sv
// regfile_wb_sched_pkg: shared sizes, register-zero constant and requester indices
package regfile_wb_sched_pkg;
    localparam int NREQ = 3;
    localparam int AW = 5;
    localparam int DW = 32;
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int NREG = 1 << AW;
    localparam int REQ_ALU = 0;
    localparam int REQ_LOAD = 1;
    localparam int REQ_MULDIV = 2;
    typedef logic [AW-1:0] reg_t;
    typedef logic [DW-1:0] data_t;
    localparam reg_t REG_ZERO = '0;
endpackage

// File: rtl/regfile_wb_sched_if.sv
// regfile_wb_sched_if: write-back requests, scoreboard reserve/query and register-file write port
//   master: execution units / decode side; slave: the scheduler
interface regfile_wb_sched_if;
    import regfile_wb_sched_pkg::*;
    logic [NREQ-1:0] req_valid;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0] req_ready;
    logic hold;
    logic resv_valid;
    reg_t resv_reg;
    reg_t busy_reg1;
    reg_t busy_reg2;
    logic busy1;
    logic busy2;
    logic we;
    reg_t write_reg;
    data_t write_data;
    modport master (
        output req_valid, req_addr, req_data, hold, resv_valid, resv_reg, busy_reg1, busy_reg2,
        input req_ready, busy1, busy2, we, write_reg, write_data
    );
    modport slave (
        input req_valid, req_addr, req_data, hold, resv_valid, resv_reg, busy_reg1, busy_reg2,
        output req_ready, busy1, busy2, we, write_reg, write_data
    );
endinterface

// File: rtl/regfile_wb_sched_arb.sv
// rr_arbiter: combinational round-robin pick, scanning from last+1 and wrapping
//   req: request vector; last: previously granted index
//   gnt: one-hot grant; idx: granted index (last when none); any: a grant was made
module rr_arbiter #(
    parameter int NREQ = 3,
    parameter int IW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   idx,
    output logic            any
);
    always_comb begin
        gnt = '0;
        idx = last;
        any = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            logic [IW-1:0] j;
            j = IW'((int'(last) + k) % NREQ);
            if (!any && req[j]) begin
                any = 1'b1;
                idx = j;
                gnt[j] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/regfile_wb_sched.sv
// regfile_wb_sched: shares the register-file write port among requesters and tracks pending writes
//   clk, rst_n: clock and asynchronous active-low reset
//   bus: requests/grants, hold, reservation, busy queries and the registered write port
module regfile_wb_sched
    import regfile_wb_sched_pkg::*;
(
    input logic clk,
    input logic rst_n,
    regfile_wb_sched_if.slave bus
);
    logic [NREQ-1:0] gnt;
    logic [IW-1:0] idx;
    logic [IW-1:0] last;
    logic any;
    reg_t g_addr;
    data_t g_data;
    logic we;
    reg_t write_reg;
    data_t write_data;
    logic [NREG-1:0] pend;
    logic [NREG-1:0] pend_nxt;
    rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
        .req  (bus.req_valid & {NREQ{~bus.hold}}),
        .last (last),
        .gnt  (gnt),
        .idx  (idx),
        .any  (any)
    );
    assign g_addr = bus.req_addr[int'(idx)*AW +: AW];
    assign g_data = bus.req_data[int'(idx)*DW +: DW];
    // $0 writes still take the slot and move the pointer; only WE is suppressed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last <= IW'(NREQ - 1);
            we <= 1'b0;
            write_reg <= REG_ZERO;
            write_data <= '0;
        end else begin
            we <= any && (g_addr != REG_ZERO);
            if (any) begin
                last <= idx;
                write_reg <= g_addr;
                write_data <= g_data;
            end
        end
    end
    // reservation applied after the clear so a same-edge re-reservation keeps the bit set
    always_comb begin
        pend_nxt = pend;
        if (we) pend_nxt[write_reg] = 1'b0;
        if (bus.resv_valid) pend_nxt[bus.resv_reg] = 1'b1;
        pend_nxt[0] = 1'b0;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pend <= '0;
        else pend <= pend_nxt;
    end
    assign bus.req_ready = gnt;
    assign bus.we = we;
    assign bus.write_reg = write_reg;
    assign bus.write_data = write_data;
    assign bus.busy1 = pend[bus.busy_reg1];
    assign bus.busy2 = pend[bus.busy_reg2];
endmodule

// File: tb/tb_regfile_wb_sched.sv
// tb_regfile_wb_sched: directed vector table plus reset sequence for regfile_wb_sched
module tb_regfile_wb_sched;
    logic clk;
    logic rst_n;
    int n_chk;
    int n_bad;
    regfile_wb_sched_if bus();
    regfile_wb_sched dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        logic [2:0] v;
        logic [4:0] a0, a1, a2;
        logic [31:0] d0, d1, d2;
        logic hold, rv;
        logic [4:0] rr, q1, q2;
        logic [2:0] rdy;
        logic we;
        logic [4:0] wr;
        logic [31:0] wd;
        logic b1, b2;
    } vec_t;

    vec_t tv[26];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [2:0] v, input logic hold, input logic rv, input logic [4:0] rr,
                                input logic [4:0] q1, input logic [4:0] q2, input logic [2:0] rdy,
                                input logic we, input logic [4:0] wr, input logic [31:0] wd,
                                input logic b1, input logic b2);
        vec_t t;
        t.v = v; t.a0 = 5'd1; t.a1 = 5'd2; t.a2 = 5'd3;
        t.d0 = 32'h100; t.d1 = 32'h200; t.d2 = 32'h300;
        t.hold = hold; t.rv = rv; t.rr = rr; t.q1 = q1; t.q2 = q2;
        t.rdy = rdy; t.we = we; t.wr = wr; t.wd = wd; t.b1 = b1; t.b2 = b2;
        return t;
    endfunction

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s vec %0d: got %0h expected %0h", nm, k, act, exp);
        end
    endtask

    task automatic drive(input vec_t t);
        bus.req_valid = t.v;
        bus.req_addr = {t.a2, t.a1, t.a0};
        bus.req_data = {t.d2, t.d1, t.d0};
        bus.hold = t.hold;
        bus.resv_valid = t.rv;
        bus.resv_reg = t.rr;
        bus.busy_reg1 = t.q1;
        bus.busy_reg2 = t.q2;
    endtask

    initial begin
        n_chk = 0;
        n_bad = 0;
        tv[0]  = mk(3'b000, 0, 0, 0, 0, 0, 3'b000, 0, 0, 32'h0, 0, 0);
        tv[1]  = mk(3'b010, 0, 0, 0, 7, 0, 3'b010, 0, 0, 32'h0, 0, 0);
        tv[1].a1 = 5'd7; tv[1].d1 = 32'hDEADBEEF;
        tv[2]  = mk(3'b000, 0, 0, 0, 7, 0, 3'b000, 1, 7, 32'hDEADBEEF, 0, 0);
        tv[3]  = mk(3'b111, 0, 0, 0, 0, 0, 3'b100, 0, 7, 32'hDEADBEEF, 0, 0);
        tv[4]  = mk(3'b111, 0, 0, 0, 0, 0, 3'b001, 1, 3, 32'h300, 0, 0);
        tv[5]  = mk(3'b111, 0, 0, 0, 0, 0, 3'b010, 1, 1, 32'h100, 0, 0);
        tv[6]  = mk(3'b111, 0, 0, 0, 0, 0, 3'b100, 1, 2, 32'h200, 0, 0);
        tv[7]  = mk(3'b111, 0, 0, 0, 0, 0, 3'b001, 1, 3, 32'h300, 0, 0);
        tv[8]  = mk(3'b111, 0, 0, 0, 0, 0, 3'b010, 1, 1, 32'h100, 0, 0);
        tv[9]  = mk(3'b001, 0, 0, 0, 0, 0, 3'b001, 1, 2, 32'h200, 0, 0);
        tv[9].a0 = 5'd0; tv[9].d0 = 32'h5;
        tv[10] = mk(3'b111, 0, 0, 0, 0, 0, 3'b010, 0, 0, 32'h5, 0, 0);
        tv[11] = mk(3'b000, 0, 0, 0, 0, 0, 3'b000, 1, 2, 32'h200, 0, 0);
        tv[12] = mk(3'b000, 0, 1, 9, 9, 9, 3'b000, 0, 2, 32'h200, 0, 0);
        tv[13] = mk(3'b100, 0, 0, 0, 9, 9, 3'b100, 0, 2, 32'h200, 1, 1);
        tv[13].a2 = 5'd9; tv[13].d2 = 32'h99;
        tv[14] = mk(3'b000, 0, 0, 0, 9, 9, 3'b000, 1, 9, 32'h99, 1, 1);
        tv[15] = mk(3'b000, 0, 0, 0, 9, 9, 3'b000, 0, 9, 32'h99, 0, 0);
        tv[16] = mk(3'b000, 0, 1, 9, 9, 9, 3'b000, 0, 9, 32'h99, 0, 0);
        tv[17] = mk(3'b100, 0, 0, 0, 9, 9, 3'b100, 0, 9, 32'h99, 1, 1);
        tv[17].a2 = 5'd9; tv[17].d2 = 32'hAA;
        tv[18] = mk(3'b000, 0, 1, 9, 9, 9, 3'b000, 1, 9, 32'hAA, 1, 1);
        tv[19] = mk(3'b000, 0, 0, 0, 9, 0, 3'b000, 0, 9, 32'hAA, 1, 0);
        tv[20] = mk(3'b111, 0, 0, 0, 0, 0, 3'b001, 0, 9, 32'hAA, 0, 0);
        tv[21] = mk(3'b111, 1, 0, 0, 0, 0, 3'b000, 1, 1, 32'h100, 0, 0);
        tv[22] = mk(3'b111, 1, 0, 0, 0, 0, 3'b000, 0, 1, 32'h100, 0, 0);
        tv[23] = mk(3'b111, 1, 0, 0, 0, 0, 3'b000, 0, 1, 32'h100, 0, 0);
        tv[24] = mk(3'b111, 0, 0, 0, 0, 0, 3'b010, 0, 1, 32'h100, 0, 0);
        tv[25] = mk(3'b000, 0, 0, 0, 0, 0, 3'b000, 1, 2, 32'h200, 0, 0);

        rst_n = 1'b0;
        drive(tv[0]);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 26; i++) begin
            @(negedge clk);
            drive(tv[i]);
            #1;
            chk("req_ready", i, 32'(bus.req_ready), 32'(tv[i].rdy));
            chk("we", i, 32'(bus.we), 32'(tv[i].we));
            chk("write_reg", i, 32'(bus.write_reg), 32'(tv[i].wr));
            chk("write_data", i, bus.write_data, tv[i].wd);
            chk("busy1", i, 32'(bus.busy1), 32'(tv[i].b1));
            chk("busy2", i, 32'(bus.busy2), 32'(tv[i].b2));
        end

        // asynchronous reset in the middle of a cycle carrying a write and a reservation
        @(negedge clk);
        drive(mk(3'b111, 0, 1, 5, 5, 9, 0, 0, 0, 0, 0, 0));
        #1;
        chk("rst_pre_ready", 100, 32'(bus.req_ready), 32'b100);
        @(posedge clk);
        #2;
        bus.resv_valid = 1'b0;
        chk("rst_pre_we", 100, 32'(bus.we), 32'd1);
        chk("rst_pre_busy1", 100, 32'(bus.busy1), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_we", 101, 32'(bus.we), 32'd0);
        chk("rst_write_reg", 101, 32'(bus.write_reg), 32'd0);
        chk("rst_write_data", 101, bus.write_data, 32'd0);
        chk("rst_busy1", 101, 32'(bus.busy1), 32'd0);
        chk("rst_busy2", 101, 32'(bus.busy2), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_ready", 102, 32'(bus.req_ready), 32'b001);
        @(posedge clk);
        #1;
        chk("post_rst_we", 103, 32'(bus.we), 32'd1);
        chk("post_rst_write_reg", 103, 32'(bus.write_reg), 32'd1);
        chk("post_rst_write_data", 103, bus.write_data, 32'h100);
        chk("post_rst_ready2", 103, 32'(bus.req_ready), 32'b010);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
        $finish;
    end
endmodule
